// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage pipeline.
//   - forwards rs1/rs2 from the MEM stage (this block's own EX/MEM register)
//     or from the WB stage (RegWrite_pype3/WReg_pype3/wb_data)
//   - single-cycle ALU, plus a shift-add multiplier (MUL / MULHU) that
//     retires one multiplier bit per cycle
//   - computes branch / JALR targets and PC+4
//   - registers everything into the EX/MEM (_pype2) register
// Ports:
//   clk, rst (async, active low), keep (hold _pype2), nop (flush _pype2)
//   *_pype1            : ID/EX fields from decode
//   RegWrite_pype3, WReg_pype3, wb_data : WB-stage forwarding source
//   mul_busy           : upstream must hold ID/EX while high
//   *_pype2, ALU_co_pype : EX/MEM register outputs
// The MEM-stage forwarding tag is the EX/MEM register itself, so
// RegWrite_pype2/WReg_pype2/ALU_co_pype are read back internally rather
// than being separate input ports (they would collide with the outputs).
module execute_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        nop,
    input  logic        RegWrite_pype1,
    input  logic [2:0]  MemBranch_pype1,
    input  logic [1:0]  MemtoReg_pype1,
    input  logic [1:0]  MemRW_pype1,
    input  logic [3:0]  ALUOp_pype1,
    input  logic        ALUSrc_pype1,
    input  logic        PCSrc_pype1,
    input  logic        JALR_pype1,
    input  logic [31:0] PC_pype1,
    input  logic [31:0] read_data1_pype1,
    input  logic [31:0] read_data2_pype1,
    input  logic [31:0] imm_pype1,
    input  logic [4:0]  RS1_pype1,
    input  logic [4:0]  RS2_pype1,
    input  logic [4:0]  WReg_pype1,
    input  logic [31:0] Instraction_pype1,
    input  logic        RegWrite_pype3,
    input  logic [4:0]  WReg_pype3,
    input  logic [31:0] wb_data,
    output logic [31:0] ALU_co_pype,
    output logic        mul_busy,
    output logic        RegWrite_pype2,
    output logic [2:0]  MemBranch_pype2,
    output logic [1:0]  MemtoReg_pype2,
    output logic [1:0]  MemRW_pype2,
    output logic [31:0] PCBranch_pype2,
    output logic [31:0] PCp4_pype2,
    output logic [31:0] read_data2_pype2,
    output logic [4:0]  WReg_pype2,
    output logic [31:0] Instraction_pype2
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_LUI   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // EX/MEM register
    logic        r_RegWrite;
    logic [2:0]  r_MemBranch;
    logic [1:0]  r_MemtoReg;
    logic [1:0]  r_MemRW;
    logic [31:0] r_ALU_co;
    logic [31:0] r_PCBranch;
    logic [31:0] r_PCp4;
    logic [31:0] r_rd2;
    logic [4:0]  r_WReg;
    logic [31:0] r_Instr;

    // multiplier
    state_t      r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic [63:0] r_acc;
    logic        r_mul_hi;

    logic        w_is_mul;
    logic        w_issue;
    logic        w_step;
    logic        w_done;

    logic [31:0] w_fwd_rs1;
    logic [31:0] w_fwd_rs2;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [32:0] w_sub;
    logic [31:0] w_alu;
    logic [31:0] w_target;
    logic [31:0] w_mul_res;

    // ---------------- forwarding (MEM beats WB, x0 never forwarded)
    always_comb begin
        w_fwd_rs1 = read_data1_pype1;
        if (RS1_pype1 != 5'd0) begin
            if (r_RegWrite && (r_WReg == RS1_pype1))
                w_fwd_rs1 = r_ALU_co;
            else if (RegWrite_pype3 && (WReg_pype3 == RS1_pype1))
                w_fwd_rs1 = wb_data;
        end
    end

    always_comb begin
        w_fwd_rs2 = read_data2_pype1;
        if (RS2_pype1 != 5'd0) begin
            if (r_RegWrite && (r_WReg == RS2_pype1))
                w_fwd_rs2 = r_ALU_co;
            else if (RegWrite_pype3 && (WReg_pype3 == RS2_pype1))
                w_fwd_rs2 = wb_data;
        end
    end

    assign w_op_a = PCSrc_pype1  ? PC_pype1  : w_fwd_rs1;
    assign w_op_b = ALUSrc_pype1 ? imm_pype1 : w_fwd_rs2;

    // ---------------- single-cycle ALU
    always_comb begin
        // 33-bit subtract: bit 32 is the unsigned borrow (a < b)
        w_sub = {1'b0, w_op_a} - {1'b0, w_op_b};
        w_alu = 32'd0;
        case (ALUOp_pype1)
            OP_ADD:  w_alu = w_op_a + w_op_b;
            OP_SUB:  w_alu = w_sub[31:0];
            OP_AND:  w_alu = w_op_a & w_op_b;
            OP_OR:   w_alu = w_op_a | w_op_b;
            OP_XOR:  w_alu = w_op_a ^ w_op_b;
            OP_SLL:  w_alu = w_op_a << w_op_b[4:0];
            OP_SRL:  w_alu = w_op_a >> w_op_b[4:0];
            OP_SRA:  w_alu = $unsigned($signed(w_op_a) >>> w_op_b[4:0]);
            // signs differ -> the negative one is smaller; else borrow decides
            OP_SLT:  w_alu = {31'd0, (w_op_a[31] ^ w_op_b[31]) ? w_op_a[31] : w_sub[32]};
            OP_SLTU: w_alu = {31'd0, w_sub[32]};
            OP_LUI:  w_alu = w_op_b;
            default: w_alu = 32'd0;
        endcase
    end

    assign w_target  = JALR_pype1 ? ((w_fwd_rs1 + imm_pype1) & ~32'd1)
                                  : (PC_pype1 + imm_pype1);
    assign w_mul_res = r_mul_hi ? r_acc[63:32] : r_acc[31:0];
    assign w_is_mul  = (ALUOp_pype1 == OP_MUL) || (ALUOp_pype1 == OP_MULHU);

    // ---------------- multiplier FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_step      = 1'b0;
        w_done      = 1'b0;
        if (nop) begin
            w_state_nxt = S_IDLE;
        end else if (!keep) begin
            case (r_state)
                S_IDLE: if (w_is_mul) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    w_step = 1'b1;
                    if (r_cnt == CW'(MUL_CYCLES - 1)) w_state_nxt = S_DONE;
                end
                S_DONE: begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Busy covers the issue cycle too, so the MUL stays in ID/EX until
    // DONE writes it out; gated by rst so reset forces it low at once.
    assign mul_busy = rst & ((r_state == S_RUN) | w_issue);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_mul_a  <= 32'd0;
            r_mul_b  <= 32'd0;
            r_acc    <= 64'd0;
            r_mul_hi <= 1'b0;
        end else if (w_issue) begin
            r_cnt    <= '0;
            r_mul_a  <= w_op_a;
            r_mul_b  <= w_op_b;
            r_acc    <= 64'd0;
            r_mul_hi <= (ALUOp_pype1 == OP_MULHU);
        end else if (w_step) begin
            if (r_mul_b[0]) r_acc <= r_acc + ({32'd0, r_mul_a} << r_cnt);
            r_mul_b <= r_mul_b >> 1;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // ---------------- EX/MEM register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_RegWrite  <= 1'b0;
            r_MemBranch <= 3'd0;
            r_MemtoReg  <= 2'd0;
            r_MemRW     <= 2'd0;
            r_ALU_co    <= 32'd0;
            r_PCBranch  <= 32'd0;
            r_PCp4      <= 32'd0;
            r_rd2       <= 32'd0;
            r_WReg      <= 5'd0;
            r_Instr     <= 32'd0;
        end else if (nop) begin
            // flush: PCp4, Instraction and store data are left as they were
            r_RegWrite  <= 1'b0;
            r_MemBranch <= 3'd0;
            r_MemtoReg  <= 2'd0;
            r_MemRW     <= 2'd0;
            r_ALU_co    <= 32'd0;
            r_PCBranch  <= 32'd0;
            r_WReg      <= 5'd0;
        end else if (!keep) begin
            r_PCBranch <= w_target;
            r_PCp4     <= PC_pype1 + 32'd4;
            r_rd2      <= w_fwd_rs2;
            r_WReg     <= WReg_pype1;
            r_Instr    <= Instraction_pype1;
            if (w_issue || w_step) begin
                // multiply in flight: side-effect-free bubble
                r_RegWrite  <= 1'b0;
                r_MemBranch <= 3'd0;
                r_MemtoReg  <= 2'd0;
                r_MemRW     <= 2'd0;
                r_ALU_co    <= 32'd0;
            end else begin
                r_RegWrite  <= RegWrite_pype1;
                r_MemBranch <= MemBranch_pype1;
                r_MemtoReg  <= MemtoReg_pype1;
                r_MemRW     <= MemRW_pype1;
                r_ALU_co    <= w_done ? w_mul_res : w_alu;
            end
        end
    end

    assign RegWrite_pype2    = r_RegWrite;
    assign MemBranch_pype2   = r_MemBranch;
    assign MemtoReg_pype2    = r_MemtoReg;
    assign MemRW_pype2       = r_MemRW;
    assign ALU_co_pype       = r_ALU_co;
    assign PCBranch_pype2    = r_PCBranch;
    assign PCp4_pype2        = r_PCp4;
    assign read_data2_pype2  = r_rd2;
    assign WReg_pype2        = r_WReg;
    assign Instraction_pype2 = r_Instr;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed steps followed by random
// single-cycle traffic and random multiplies, compared against a
// behavioural model of the EX/MEM register contents.
module tb_execute_stage;
    localparam int MUL_CYCLES = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        keep, nop;
    logic        RegWrite_pype1;
    logic [2:0]  MemBranch_pype1;
    logic [1:0]  MemtoReg_pype1, MemRW_pype1;
    logic [3:0]  ALUOp_pype1;
    logic        ALUSrc_pype1, PCSrc_pype1, JALR_pype1;
    logic [31:0] PC_pype1, read_data1_pype1, read_data2_pype1, imm_pype1;
    logic [4:0]  RS1_pype1, RS2_pype1, WReg_pype1;
    logic [31:0] Instraction_pype1;
    logic        RegWrite_pype3;
    logic [4:0]  WReg_pype3;
    logic [31:0] wb_data;
    logic [31:0] ALU_co_pype;
    logic        mul_busy;
    logic        RegWrite_pype2;
    logic [2:0]  MemBranch_pype2;
    logic [1:0]  MemtoReg_pype2, MemRW_pype2;
    logic [31:0] PCBranch_pype2, PCp4_pype2, read_data2_pype2;
    logic [4:0]  WReg_pype2;
    logic [31:0] Instraction_pype2;

    execute_stage #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .rst(rst), .keep(keep), .nop(nop),
        .RegWrite_pype1(RegWrite_pype1), .MemBranch_pype1(MemBranch_pype1),
        .MemtoReg_pype1(MemtoReg_pype1), .MemRW_pype1(MemRW_pype1),
        .ALUOp_pype1(ALUOp_pype1), .ALUSrc_pype1(ALUSrc_pype1),
        .PCSrc_pype1(PCSrc_pype1), .JALR_pype1(JALR_pype1), .PC_pype1(PC_pype1),
        .read_data1_pype1(read_data1_pype1), .read_data2_pype1(read_data2_pype1),
        .imm_pype1(imm_pype1), .RS1_pype1(RS1_pype1), .RS2_pype1(RS2_pype1),
        .WReg_pype1(WReg_pype1), .Instraction_pype1(Instraction_pype1),
        .RegWrite_pype3(RegWrite_pype3), .WReg_pype3(WReg_pype3), .wb_data(wb_data),
        .ALU_co_pype(ALU_co_pype), .mul_busy(mul_busy),
        .RegWrite_pype2(RegWrite_pype2), .MemBranch_pype2(MemBranch_pype2),
        .MemtoReg_pype2(MemtoReg_pype2), .MemRW_pype2(MemRW_pype2),
        .PCBranch_pype2(PCBranch_pype2), .PCp4_pype2(PCp4_pype2),
        .read_data2_pype2(read_data2_pype2), .WReg_pype2(WReg_pype2),
        .Instraction_pype2(Instraction_pype2)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // expected EX/MEM contents
    logic        e_rw;
    logic [2:0]  e_mb;
    logic [1:0]  e_m2r, e_mrw;
    logic [31:0] e_alu, e_pcb, e_pcp4, e_rd2, e_ins;
    logic [4:0]  e_wr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_rw = 0; e_mb = 0; e_m2r = 0; e_mrw = 0; e_alu = 0;
        e_pcb = 0; e_pcp4 = 0; e_rd2 = 0; e_ins = 0; e_wr = 0;
    endtask

    function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return rf;
        if (e_rw && e_wr == rs) return e_alu;
        if (RegWrite_pype3 && WReg_pype3 == rs) return wb_data;
        return rf;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int s;
        s = int'(b[4:0]);
        p = {32'd0, a} * {32'd0, b};
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << s;
            4'd6:  return a >> s;
            4'd7:  return (a >> s) | (a[31] ? ~(32'hFFFFFFFF >> s) : 32'd0);
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return b;
            4'd11: return p[31:0];
            4'd12: return p[63:32];
            default: return 32'd0;
        endcase
    endfunction

    // expected effect of one clock edge for a non-multiply instruction
    task automatic model_edge();
        logic [31:0] f1, f2, a, b;
        f1 = m_fwd(RS1_pype1, read_data1_pype1);
        f2 = m_fwd(RS2_pype1, read_data2_pype1);
        a  = PCSrc_pype1  ? PC_pype1  : f1;
        b  = ALUSrc_pype1 ? imm_pype1 : f2;
        if (nop) begin
            e_rw = 0; e_mb = 0; e_m2r = 0; e_mrw = 0; e_wr = 0; e_alu = 0; e_pcb = 0;
        end else if (!keep) begin
            e_rw   = RegWrite_pype1;
            e_mb   = MemBranch_pype1;
            e_m2r  = MemtoReg_pype1;
            e_mrw  = MemRW_pype1;
            e_alu  = m_alu(ALUOp_pype1, a, b);
            e_pcb  = JALR_pype1 ? ((f1 + imm_pype1) & ~32'd1) : (PC_pype1 + imm_pype1);
            e_pcp4 = PC_pype1 + 32'd4;
            e_rd2  = f2;
            e_ins  = Instraction_pype1;
            e_wr   = WReg_pype1;
        end
    endtask

    task automatic check_all(input string t);
        chk({t, ".RegWrite"},  RegWrite_pype2,    e_rw);
        chk({t, ".MemBranch"}, MemBranch_pype2,   e_mb);
        chk({t, ".MemtoReg"},  MemtoReg_pype2,    e_m2r);
        chk({t, ".MemRW"},     MemRW_pype2,       e_mrw);
        chk({t, ".ALU_co"},    ALU_co_pype,       e_alu);
        chk({t, ".PCBranch"},  PCBranch_pype2,    e_pcb);
        chk({t, ".PCp4"},      PCp4_pype2,        e_pcp4);
        chk({t, ".rd2"},       read_data2_pype2,  e_rd2);
        chk({t, ".WReg"},      WReg_pype2,        e_wr);
        chk({t, ".Instr"},     Instraction_pype2, e_ins);
    endtask

    task automatic step(input string t);
        model_edge();
        @(posedge clk); #1;
        check_all(t);
    endtask

    task automatic clear_in();
        keep = 0; nop = 0; RegWrite_pype1 = 0; MemBranch_pype1 = 0;
        MemtoReg_pype1 = 0; MemRW_pype1 = 0; ALUOp_pype1 = 0; ALUSrc_pype1 = 0;
        PCSrc_pype1 = 0; JALR_pype1 = 0; PC_pype1 = 0; read_data1_pype1 = 0;
        read_data2_pype1 = 0; imm_pype1 = 0; RS1_pype1 = 0; RS2_pype1 = 0;
        WReg_pype1 = 0; Instraction_pype1 = 0; RegWrite_pype3 = 0;
        WReg_pype3 = 0; wb_data = 0;
    endtask

    // issue a MUL/MULHU and follow it to completion (fixed cycle budget)
    task automatic run_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] wr);
        logic [63:0] p;
        logic [31:0] exp;
        int busy_cnt;
        clear_in();
        ALUOp_pype1 = op; RS1_pype1 = 5'd20; RS2_pype1 = 5'd21;
        read_data1_pype1 = a; read_data2_pype1 = b;
        RegWrite_pype1 = 1; WReg_pype1 = wr; PC_pype1 = 32'h300; imm_pype1 = 32'h10;
        Instraction_pype1 = {28'h0BADC0D, op};
        p   = {32'd0, m_fwd(5'd20, a)} * {32'd0, m_fwd(5'd21, b)};
        exp = (op == 4'd12) ? p[63:32] : p[31:0];
        busy_cnt = 0;
        #1;
        if (mul_busy) busy_cnt++;
        for (int k = 1; k <= MUL_CYCLES + 2; k++) begin
            @(posedge clk); #1;
            if (k <= MUL_CYCLES + 1) begin
                chk("mul_bubble", {RegWrite_pype2, MemRW_pype2, MemBranch_pype2, MemtoReg_pype2}, 0);
                if (mul_busy) busy_cnt++;
            end
        end
        chk("mul_result", ALU_co_pype, exp);
        chk("mul_busy_cycles", busy_cnt, MUL_CYCLES + 1);
        e_rw = 1; e_mb = 0; e_m2r = 0; e_mrw = 0; e_alu = exp;
        e_pcb = 32'h310; e_pcp4 = 32'h304; e_rd2 = b; e_ins = {28'h0BADC0D, op}; e_wr = wr;
        check_all("mul_done");
        clear_in();
        #1;
        chk("mul_busy_after", mul_busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset
        rst = 0;
        clear_in();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.busy", mul_busy, 0);
        #2 rst = 1;

        // ---- ADD x3 = x1 + x2 (5 + 0xFFFFFFFE)
        @(posedge clk); #1;
        RegWrite_pype1 = 1; RS1_pype1 = 1; RS2_pype1 = 2; WReg_pype1 = 3;
        read_data1_pype1 = 32'd5; read_data2_pype1 = 32'hFFFFFFFE;
        PC_pype1 = 32'h100; imm_pype1 = 32'h8; Instraction_pype1 = 32'h002081B3;
        step("add");
        chk("add.const", ALU_co_pype, 32'd3);
        chk("add.pcp4", PCp4_pype2, 32'h104);

        // ---- forwarding: x1=7 in MEM, 9 in WB
        clear_in();
        RegWrite_pype1 = 1; ALUSrc_pype1 = 1; imm_pype1 = 32'd7; WReg_pype1 = 1;
        step("addi_x1");
        clear_in();
        RegWrite_pype3 = 1; WReg_pype3 = 1; wb_data = 32'd9;
        RegWrite_pype1 = 1; RS1_pype1 = 1; read_data1_pype1 = 32'h55; WReg_pype1 = 5;
        step("fwd_mem");
        chk("fwd_mem.const", ALU_co_pype, 32'd7);
        // MEM now tags x5, so x1 comes from WB
        WReg_pype1 = 0;
        step("fwd_wb");
        chk("fwd_wb.const", ALU_co_pype, 32'd9);
        // x0 is never forwarded even with matching tags
        clear_in();
        RegWrite_pype3 = 1; WReg_pype3 = 0; wb_data = 32'd9;
        RegWrite_pype1 = 1; WReg_pype1 = 9;
        step("fwd_x0");
        chk("fwd_x0.const", ALU_co_pype, 32'd0);

        // ---- BLT via SLT, then JALR
        clear_in();
        ALUOp_pype1 = 4'd8; RS1_pype1 = 6; RS2_pype1 = 7;
        read_data1_pype1 = 32'hFFFFFFFF; read_data2_pype1 = 32'd1;
        PC_pype1 = 32'h200; imm_pype1 = 32'h40; MemBranch_pype1 = 3'd4;
        step("blt");
        chk("blt.const", ALU_co_pype, 32'd1);
        chk("blt.target", PCBranch_pype2, 32'h240);
        clear_in();
        ALUSrc_pype1 = 1; JALR_pype1 = 1; RS1_pype1 = 8; read_data1_pype1 = 32'h1001;
        imm_pype1 = 32'd2; RegWrite_pype1 = 1; WReg_pype1 = 1; PC_pype1 = 32'h400;
        step("jalr");
        chk("jalr.target", PCBranch_pype2, 32'h1002);

        // ---- keep for 3 cycles with an ADD pending
        clear_in();
        RegWrite_pype1 = 1; RS1_pype1 = 12; RS2_pype1 = 13; WReg_pype1 = 4;
        read_data1_pype1 = 32'd10; read_data2_pype1 = 32'd20; PC_pype1 = 32'h500;
        keep = 1;
        step("keep1");
        step("keep2");
        step("keep3");
        chk("keep.frozen", ALU_co_pype, 32'h1003);
        keep = 0;
        step("keep_release");
        chk("keep_release.const", ALU_co_pype, 32'd30);

        // ---- multiplies
        run_mul(4'd11, 32'h10000, 32'h10000, 5'd5);
        chk("mul.const", ALU_co_pype, 32'd0);
        run_mul(4'd12, 32'h10000, 32'h10000, 5'd6);
        chk("mulhu.const", ALU_co_pype, 32'd1);

        // ---- nop during a multiply
        clear_in();
        ALUOp_pype1 = 4'd11; RS1_pype1 = 20; RS2_pype1 = 21;
        read_data1_pype1 = 32'd3; read_data2_pype1 = 32'd5;
        RegWrite_pype1 = 1; WReg_pype1 = 6; PC_pype1 = 32'h500; Instraction_pype1 = 32'hCAFE0001;
        #1;
        chk("nopmul.busy_issue", mul_busy, 1);
        repeat (5) begin @(posedge clk); #1; end
        chk("nopmul.busy_run", mul_busy, 1);
        clear_in();
        nop = 1;
        @(posedge clk); #1;
        chk("nop.fields", {RegWrite_pype2, MemBranch_pype2, MemtoReg_pype2, MemRW_pype2, WReg_pype2}, 0);
        chk("nop.alu", ALU_co_pype, 0);
        chk("nop.pcb", PCBranch_pype2, 0);
        chk("nop.pcp4_held", PCp4_pype2, 32'h504);
        chk("nop.instr_held", Instraction_pype2, 32'hCAFE0001);
        chk("nop.busy", mul_busy, 0);
        e_rw = 0; e_mb = 0; e_m2r = 0; e_mrw = 0; e_wr = 0; e_alu = 0; e_pcb = 0;
        nop = 0;
        RegWrite_pype1 = 1; RS1_pype1 = 14; RS2_pype1 = 15; WReg_pype1 = 7;
        read_data1_pype1 = 32'd1; read_data2_pype1 = 32'd2; PC_pype1 = 32'h600;
        step("after_abort");
        chk("after_abort.const", ALU_co_pype, 32'd3);

        // ---- reset in the middle of a multiply
        clear_in();
        ALUOp_pype1 = 4'd11; RS1_pype1 = 20; RS2_pype1 = 21;
        read_data1_pype1 = 32'd3; read_data2_pype1 = 32'd4; RegWrite_pype1 = 1; WReg_pype1 = 2;
        repeat (10) begin @(posedge clk); #1; end
        chk("rstmul.busy_before", mul_busy, 1);
        rst = 0;
        #1;
        model_reset();
        check_all("rst_mid_mul");
        chk("rst_mid_mul.busy", mul_busy, 0);
        clear_in();
        RegWrite_pype1 = 1; RS1_pype1 = 1; RS2_pype1 = 2; WReg_pype1 = 3;
        read_data1_pype1 = 32'd5; read_data2_pype1 = 32'hFFFFFFFE; PC_pype1 = 32'h700;
        #2 rst = 1;
        step("after_reset");
        chk("after_reset.const", ALU_co_pype, 32'd3);

        // ---- random single-cycle traffic
        for (int i = 0; i < 300; i++) begin
            keep              = ($urandom_range(0, 7) == 0);
            nop               = ($urandom_range(0, 7) == 0);
            RegWrite_pype1    = 1'($urandom);
            MemBranch_pype1   = 3'($urandom);
            MemtoReg_pype1    = 2'($urandom);
            MemRW_pype1       = 2'($urandom);
            ALUOp_pype1       = 4'($urandom_range(0, 10));
            ALUSrc_pype1      = 1'($urandom);
            PCSrc_pype1       = ($urandom_range(0, 3) == 0);
            JALR_pype1        = ($urandom_range(0, 3) == 0);
            PC_pype1          = $urandom;
            read_data1_pype1  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            read_data2_pype1  = $urandom;
            imm_pype1         = $urandom;
            RS1_pype1         = 5'($urandom_range(0, 3));
            RS2_pype1         = 5'($urandom_range(0, 3));
            WReg_pype1        = 5'($urandom_range(0, 3));
            Instraction_pype1 = $urandom;
            RegWrite_pype3    = 1'($urandom);
            WReg_pype3        = 5'($urandom_range(0, 3));
            wb_data           = $urandom;
            step("rand");
        end

        // ---- random multiplies
        for (int i = 0; i < 4; i++) begin
            run_mul((i % 2 == 0) ? 4'd11 : 4'd12, $urandom, $urandom, 5'($urandom_range(1, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
